// File: rtl/fb_pkg.sv
// Framebuffer geometry and write-arbiter state encoding shared by the write path.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 640;
  localparam int unsigned FB_HEIGHT = 480;
  localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned FB_ADDR_W = 19;

  typedef enum logic [1:0] {
    ARB,
    WAIT_BUSY,
    GAP
  } fb_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search: first valid requester at or after ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  // Scan N positions starting at ptr; the first valid one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IDX_W'((32'(ptr) + k) % N);
      if (!found && valid[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin sharing of the single framebuffer pixel write port between NUM_REQ requesters.
// Out-of-range addresses are acknowledged, not written, and counted (saturating).
module fb_write_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned FB_PIXELS = fb_pkg::FB_PIXELS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*fb_pkg::FB_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]               req_data,
  output logic [NUM_REQ-1:0]                  req_ack,
  output logic [fb_pkg::FB_ADDR_W-1:0]        addr,
  output logic [31:0]                         data,
  output logic                                wr,
  input  logic                                busy,
  output logic [15:0]                         drop_count,
  output logic                                idle
);

  import fb_pkg::*;

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  fb_arb_state_t          state, state_next;
  logic [PTR_W-1:0]       ptr;
  logic [NUM_REQ-1:0]     grant;
  logic [PTR_W-1:0]       win_idx;
  logic                   any_valid;
  logic [FB_ADDR_W-1:0]   win_addr;
  logic [31:0]            win_data;
  logic                   in_range;
  logic                   take;
  logic                   write_go;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (PTR_W)
  ) u_rr (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win_idx),
    .found (any_valid)
  );

  assign win_addr = req_addr[32'(win_idx) * FB_ADDR_W +: FB_ADDR_W];
  assign win_data = req_data[32'(win_idx) * 32 +: 32];
  assign in_range = 32'(win_addr) < FB_PIXELS;

  // Next-state and per-cycle decisions of the ARB / WAIT_BUSY / GAP sequence.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    write_go   = 1'b0;
    case (state)
      ARB: begin
        if (any_valid) begin
          take = 1'b1;
          if (in_range) state_next = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!busy) begin
          write_go   = 1'b1;
          state_next = GAP;
        end
      end
      GAP:     state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ARB;
    else       state <= state_next;
  end

  // Registered outputs, request latch, rotation pointer and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= '0;
      data       <= '0;
      wr         <= 1'b0;
      req_ack    <= '0;
      drop_count <= '0;
      idle       <= 1'b1;
      ptr        <= '0;
    end else begin
      wr      <= write_go;
      req_ack <= take ? grant : '0;
      idle    <= (state_next == ARB);
      if (take) begin
        ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        if (in_range) begin
          addr <= win_addr;
          data <= win_data;
        end else if (drop_count != '1) begin
          drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: vector table, write scoreboard and corner sequences.
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [1:0]  req_valid;
  logic [37:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_ack;
  logic [18:0] addr;
  logic [31:0] data;
  logic        wr;
  logic [15:0] drop_count;
  logic        idle;

  logic [2:0]  req_valid3;
  logic [56:0] req_addr3;
  logic [95:0] req_data3;
  logic [2:0]  req_ack3;
  logic [18:0] addr3;
  logic [31:0] data3;
  logic        wr3;
  logic [15:0] drop_count3;
  logic        idle3;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [18:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  typedef struct {
    int unsigned req;
    logic [18:0] a;
    logic [31:0] d;
    logic        exp_wr;
    logic [15:0] exp_drop;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  fb_write_arbiter #(.NUM_REQ(2), .FB_PIXELS(307200)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ack(req_ack), .addr(addr), .data(data), .wr(wr),
    .busy(busy), .drop_count(drop_count), .idle(idle)
  );

  fb_write_arbiter #(.NUM_REQ(3), .FB_PIXELS(307200)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_addr(req_addr3),
    .req_data(req_data3), .req_ack(req_ack3), .addr(addr3), .data(data3), .wr(wr3),
    .busy(busy), .drop_count(drop_count3), .idle(idle3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int unsigned i, input logic [18:0] a, input logic [31:0] d);
    req_valid[i]        = 1'b1;
    req_addr[i*19 +: 19] = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    busy       = 1'b0;
    req_valid  = '0;
    req_valid3 = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Scoreboard: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (wr) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_wr: addr %0h data %0h, no write expected", addr, data);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_addr", 64'(addr), 64'(mon_e.a));
        check("sb_data", 64'(data), 64'(mon_e.d));
      end
    end
  end

  initial begin
    int          got[$];
    int          exp_order[4];
    logic [1:0]  oh;
    int unsigned ei;

    reset      = 1'b1;
    busy       = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    req_data   = '0;
    req_valid3 = '0;
    req_addr3  = '0;
    req_data3  = '0;

    vecs[0] = '{0, 19'd1234,   32'hDEADBEEF, 1'b1, 16'd0};
    vecs[1] = '{1, 19'd307199, 32'h0000CAFE, 1'b1, 16'd0};
    vecs[2] = '{1, 19'd307200, 32'h11111111, 1'b0, 16'd1};
    vecs[3] = '{0, 19'd0,      32'hA5A5A5A5, 1'b1, 16'd1};
    vecs[4] = '{0, 19'h7FFFF,  32'h22222222, 1'b0, 16'd2};
    vecs[5] = '{1, 19'd5,      32'h12345678, 1'b1, 16'd2};

    // Reset values, sampled while reset is still asserted.
    step();
    step();
    check("rst_addr", 64'(addr), 0);
    check("rst_data", 64'(data), 0);
    check("rst_wr", 64'(wr), 0);
    check("rst_ack", 64'(req_ack), 0);
    check("rst_drop", 64'(drop_count), 0);
    check("rst_idle", 64'(idle), 1);
    reset = 1'b0;
    step();

    // Table of single requests: ack at t+1, write at t+2, idle again at t+3.
    for (int v = 0; v < 6; v++) begin
      drive_req(vecs[v].req, vecs[v].a, vecs[v].d);
      if (vecs[v].exp_wr) exp_q.push_back('{vecs[v].a, vecs[v].d});
      oh = 2'b01 << vecs[v].req;
      step();
      check("vec_ack", 64'(req_ack), 64'(oh));
      check("vec_idle", 64'(idle), 64'(!vecs[v].exp_wr));
      check("vec_drop", 64'(drop_count), 64'(vecs[v].exp_drop));
      req_valid = '0;
      if (vecs[v].exp_wr) begin
        step();
        check("vec_wr", 64'(wr), 1);
        check("vec_addr", 64'(addr), 64'(vecs[v].a));
        check("vec_data", 64'(data), 64'(vecs[v].d));
        step();
        check("vec_wr_end", 64'(wr), 0);
        check("vec_idle_end", 64'(idle), 1);
      end else begin
        check("vec_nowr", 64'(wr), 0);
        step();
        check("vec_nowr2", 64'(wr), 0);
      end
    end

    // busy held high: no write, latch stable; exactly one pulse after busy falls.
    busy = 1'b1;
    drive_req(0, 19'd777, 32'h0BADF00D);
    exp_q.push_back('{19'd777, 32'h0BADF00D});
    step();
    check("busy_ack", 64'(req_ack), 64'(2'b01));
    req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("busy_wr_low", 64'(wr), 0);
      check("busy_addr", 64'(addr), 777);
      check("busy_data", 64'(data), 64'h0BADF00D);
      check("busy_noack", 64'(req_ack), 0);
    end
    busy = 1'b0;
    step();
    check("busy_wr_pulse", 64'(wr), 1);
    step();
    check("busy_wr_end", 64'(wr), 0);
    step();
    check("busy_wr_end2", 64'(wr), 0);

    // Saturation: drop_count is 2 here; continuous out-of-range requests from req1.
    drive_req(1, 19'd307200, 32'h0);
    for (int i = 0; i < 65532; i++) step();
    check("sat_pre", 64'(drop_count), 65534);
    step();
    check("sat_hit", 64'(drop_count), 65535);
    for (int i = 0; i < 5; i++) step();
    check("sat_hold", 64'(drop_count), 65535);
    check("sat_nowr", 64'(wr), 0);
    req_valid = '0;
    step();

    // Reset while in WAIT_BUSY: latched request lost, pointer back to 0.
    busy = 1'b1;
    drive_req(0, 19'd42, 32'h42424242);
    step();
    check("rstw_ack", 64'(req_ack), 64'(2'b01));
    req_valid = '0;
    reset     = 1'b1;
    busy      = 1'b0;
    step();
    check("rstw_wr", 64'(wr), 0);
    check("rstw_addr", 64'(addr), 0);
    check("rstw_data", 64'(data), 0);
    check("rstw_ack0", 64'(req_ack), 0);
    check("rstw_drop", 64'(drop_count), 0);
    check("rstw_idle", 64'(idle), 1);
    reset = 1'b0;
    step();
    check("rstw_nowr", 64'(wr), 0);
    drive_req(0, 19'd10, 32'hAAAA0000);
    drive_req(1, 19'd20, 32'hBBBB0000);
    exp_q.push_back('{19'd10, 32'hAAAA0000});
    step();
    check("rstw_ptr0", 64'(req_ack), 64'(2'b01));
    req_valid = '0;
    step();
    step();

    // Both requesters continuously valid: grants alternate 0,1,0,1,0,1.
    do_reset();
    drive_req(0, 19'd100, 32'h10000000);
    drive_req(1, 19'd200, 32'h20000000);
    for (int g = 0; g < 6; g++) begin
      ei = g % 2;
      exp_q.push_back('{req_addr[ei*19 +: 19], req_data[ei*32 +: 32]});
      oh = 2'b01 << ei;
      step();
      check("rr_ack", 64'(req_ack), 64'(oh));
      req_data[ei*32 +: 32] = req_data[ei*32 +: 32] + 32'd1;
      step();
      step();
    end
    req_valid = '0;
    step();

    // Three requesters all held valid: order 0,1,2,0.
    do_reset();
    req_valid3 = 3'b111;
    req_addr3  = {19'd3, 19'd2, 19'd1};
    req_data3  = {32'h3, 32'h2, 32'h1};
    for (int c = 0; c < 12; c++) begin
      step();
      for (int j = 0; j < 3; j++) if (req_ack3[j]) got.push_back(j);
    end
    req_valid3 = '0;
    exp_order = '{0, 1, 2, 0};
    check("rr3_count", 64'(got.size()), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < got.size()) check("rr3_order", 64'(got[k]), 64'(exp_order[k]));
    end
    step();
    step();

    check("writes_pending", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
